// File: rtl/writeback_store_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : writeback_store_queue_if                                       |
// | Purpose   : Bundles the retire, register-file, scoreboard, memory-request  |
// |             and forwarding signals of writeback_store_queue.               |
// |             slave  - seen from the writeback/store-queue block             |
// |             master - seen from the pipeline/memory side driving it         |
// | Ports     : none (signal bundle only; clk/reset stay plain module ports)   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface writeback_store_queue_if #(
  parameter int DEPTH = 4,
  parameter int NREGS = 16
);
  // retire side
  logic                      retire_valid;
  logic                      retire_ready;
  logic                      kill;
  logic                      dest_valid;
  logic [3:0]                dest_reg;
  logic [63:0]               dest_data;
  logic                      spec_valid;
  logic [3:0]                spec_reg;
  logic [63:0]               spec_data;
  logic [NREGS-1:0]          src_clr_mask;
  logic                      is_store;
  logic [63:0]               store_addr;
  logic [63:0]               store_data;
  // register file / scoreboard
  logic                      rf_wr0_en;
  logic [3:0]                rf_wr0_idx;
  logic [63:0]               rf_wr0_data;
  logic                      rf_wr1_en;
  logic [3:0]                rf_wr1_idx;
  logic [63:0]               rf_wr1_data;
  logic [NREGS-1:0]          inuse_clr;
  // memory request
  logic                      reqcyc;
  logic [63:0]               req;
  logic [63:0]               reqdata;
  logic [12:0]               reqtag;
  logic                      reqack;
  // load forwarding and status
  logic [63:0]               fwd_addr;
  logic                      fwd_hit;
  logic [63:0]               fwd_data;
  logic [$clog2(DEPTH):0]    sq_count;
  logic                      sq_empty;

  modport slave (
    input  retire_valid, kill, dest_valid, dest_reg, dest_data,
           spec_valid, spec_reg, spec_data, src_clr_mask,
           is_store, store_addr, store_data, reqack, fwd_addr,
    output retire_ready, rf_wr0_en, rf_wr0_idx, rf_wr0_data,
           rf_wr1_en, rf_wr1_idx, rf_wr1_data, inuse_clr,
           reqcyc, req, reqdata, reqtag, fwd_hit, fwd_data,
           sq_count, sq_empty
  );

  modport master (
    output retire_valid, kill, dest_valid, dest_reg, dest_data,
           spec_valid, spec_reg, spec_data, src_clr_mask,
           is_store, store_addr, store_data, reqack, fwd_addr,
    input  retire_ready, rf_wr0_en, rf_wr0_idx, rf_wr0_data,
           rf_wr1_en, rf_wr1_idx, rf_wr1_data, inuse_clr,
           reqcyc, req, reqdata, reqtag, fwd_hit, fwd_data,
           sq_count, sq_empty
  );
endinterface
`default_nettype wire

// File: rtl/writeback_store_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : writeback_store_queue                                          |
// | Purpose   : Writeback stage. Retired instructions write up to two          |
// |             register-file ports one cycle later and release scoreboard     |
// |             bits; stores are queued in a DEPTH-entry FIFO and drained to   |
// |             memory by a three-state request FSM (IDLE/REQ/GAP). Queued     |
// |             stores are searched combinationally for load forwarding.       |
// | Ports     : clk    - clock                                                 |
// |             reset  - synchronous active-high reset                         |
// |             bus    - writeback_store_queue_if.slave: retire handshake,     |
// |                      rf write ports, inuse_clr, memory request/ack,        |
// |                      forwarding lookup, sq_count/sq_empty status           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module writeback_store_queue #(
  parameter int          DEPTH  = 4,
  parameter int          NREGS  = 16,
  parameter logic [12:0] REQTAG = 13'b1_1_1_0000000_000
) (
  input  wire logic               clk,
  input  wire logic               reset,
  writeback_store_queue_if.slave  bus
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } mem_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mem_state_e        state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PTRW-1:0]   head_q,  head_d;
  logic [PTRW-1:0]   tail_q,  tail_d;

  logic [63:0]       sq_addr_q [DEPTH];
  logic [63:0]       sq_data_q [DEPTH];

  logic              reqcyc_q,  reqcyc_d;
  logic [63:0]       req_q,     req_d;
  logic [63:0]       reqdata_q, reqdata_d;

  logic              rf_wr0_en_q,   rf_wr0_en_d;
  logic [3:0]        rf_wr0_idx_q,  rf_wr0_idx_d;
  logic [63:0]       rf_wr0_data_q, rf_wr0_data_d;
  logic              rf_wr1_en_q,   rf_wr1_en_d;
  logic [3:0]        rf_wr1_idx_q,  rf_wr1_idx_d;
  logic [63:0]       rf_wr1_data_q, rf_wr1_data_d;
  logic [NREGS-1:0]  inuse_clr_q,   inuse_clr_d;

  // --------------------------------------------------------------------------
  // Retire handshake
  // --------------------------------------------------------------------------
  logic retire_ready;
  logic accept;
  logic push;
  logic pop;

  always_comb begin
    // Only a store can be back-pressured; ALU results always drain, and the
    // answer does not depend on kill.
    retire_ready = !(bus.is_store && (count_q == CNTW'(DEPTH)));
    accept       = bus.retire_valid && !bus.kill && retire_ready;
    push         = accept && bus.is_store;
    // The head leaves the queue only when memory acknowledges it in REQ.
    pop          = (state_q == ST_REQ) && bus.reqack;
  end

  // --------------------------------------------------------------------------
  // Register-file writes and scoreboard release (registered, 1-cycle pulses)
  // --------------------------------------------------------------------------
  always_comb begin
    rf_wr0_en_d   = accept && bus.dest_valid && !bus.is_store;
    // Port 0 wins a same-index collision, but only if it is really writing.
    rf_wr1_en_d   = accept && bus.spec_valid &&
                    !(rf_wr0_en_d && (bus.spec_reg == bus.dest_reg));
    rf_wr0_idx_d  = rf_wr0_idx_q;
    rf_wr0_data_d = rf_wr0_data_q;
    rf_wr1_idx_d  = rf_wr1_idx_q;
    rf_wr1_data_d = rf_wr1_data_q;
    inuse_clr_d   = '0;
    if (accept) begin
      rf_wr0_idx_d  = bus.dest_reg;
      rf_wr0_data_d = bus.dest_data;
      rf_wr1_idx_d  = bus.spec_reg;
      rf_wr1_data_d = bus.spec_data;
      inuse_clr_d   = bus.src_clr_mask
                    | (bus.dest_valid ? (NREGS'(1) << bus.dest_reg) : '0)
                    | (bus.spec_valid ? (NREGS'(1) << bus.spec_reg) : '0);
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers / occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = pop  ? head_q + PTRW'(1) : head_q;
    tail_d  = push ? tail_q + PTRW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory request FSM. req/reqdata are captured on entry to REQ and held
  // until the acknowledge, so the bus sees stable values for the whole request.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    reqcyc_d  = reqcyc_q;
    req_d     = req_q;
    reqdata_d = reqdata_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          req_d     = sq_addr_q[head_q];
          reqdata_d = sq_data_q[head_q];
          reqcyc_d  = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.reqack) begin
          reqcyc_d = 1'b0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        // Guaranteed low cycle between back-to-back transactions.
        state_d = ST_IDLE;
      end
      default: begin
        reqcyc_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Forwarding: walk oldest to youngest so the last match is the youngest.
  // The entry currently being requested stays occupied until acked, so it is
  // still searched. Stores written this cycle are not yet in the arrays.
  // --------------------------------------------------------------------------
  logic        fwd_hit;
  logic [63:0] fwd_data;

  always_comb begin
    logic [PTRW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTRW'(i);
      if ((CNTW'(i) < count_q) && (sq_addr_q[idx] == bus.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sq_data_q[idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      reqcyc_q      <= 1'b0;
      req_q         <= '0;
      reqdata_q     <= '0;
      rf_wr0_en_q   <= 1'b0;
      rf_wr0_idx_q  <= '0;
      rf_wr0_data_q <= '0;
      rf_wr1_en_q   <= 1'b0;
      rf_wr1_idx_q  <= '0;
      rf_wr1_data_q <= '0;
      inuse_clr_q   <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      reqcyc_q      <= reqcyc_d;
      req_q         <= req_d;
      reqdata_q     <= reqdata_d;
      rf_wr0_en_q   <= rf_wr0_en_d;
      rf_wr0_idx_q  <= rf_wr0_idx_d;
      rf_wr0_data_q <= rf_wr0_data_d;
      rf_wr1_en_q   <= rf_wr1_en_d;
      rf_wr1_idx_q  <= rf_wr1_idx_d;
      rf_wr1_data_q <= rf_wr1_data_d;
      inuse_clr_q   <= inuse_clr_d;
    end
  end

  // Entry storage needs no reset: occupancy is governed by count/head/tail.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      sq_addr_q[tail_q] <= bus.store_addr;
      sq_data_q[tail_q] <= bus.store_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.retire_ready = retire_ready;
  assign bus.rf_wr0_en    = rf_wr0_en_q;
  assign bus.rf_wr0_idx   = rf_wr0_idx_q;
  assign bus.rf_wr0_data  = rf_wr0_data_q;
  assign bus.rf_wr1_en    = rf_wr1_en_q;
  assign bus.rf_wr1_idx   = rf_wr1_idx_q;
  assign bus.rf_wr1_data  = rf_wr1_data_q;
  assign bus.inuse_clr    = inuse_clr_q;
  assign bus.reqcyc       = reqcyc_q;
  assign bus.req          = req_q;
  assign bus.reqdata      = reqdata_q;
  assign bus.reqtag       = REQTAG;
  assign bus.fwd_hit      = fwd_hit;
  assign bus.fwd_data     = fwd_data;
  assign bus.sq_count     = count_q;
  assign bus.sq_empty     = (count_q == '0) && (state_q != ST_REQ);

endmodule
`default_nettype wire
